// File: rtl/song_reader_pkg.sv
// Shared widths, FSM encoding and song ROM contents for the song reader.
package song_reader_pkg;

    localparam int unsigned NOTE_W = 6;
    localparam int unsigned DUR_W  = 6;
    localparam int unsigned IDX_W  = 5;
    localparam int unsigned SONG_W = 2;
    localparam int unsigned ADDR_W = SONG_W + IDX_W;
    localparam int unsigned WORD_W = NOTE_W + DUR_W;

    localparam logic [DUR_W-1:0] DUR_END  = '0;
    localparam logic [IDX_W-1:0] LAST_IDX = '1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        CHECK = 3'd2,
        ISSUE = 3'd3,
        WAIT  = 3'd4,
        END   = 3'd5,
        HOLD  = 3'd6
    } state_t;

    typedef struct packed {
        logic [NOTE_W-1:0] note;
        logic [DUR_W-1:0]  duration;
    } song_word_t;

    // Song table: songs 0 and 3 fill all 32 slots, songs 1 and 2 end on a terminator.
    function automatic song_word_t song_data(input logic [ADDR_W-1:0] addr);
        logic [SONG_W-1:0] s;
        logic [IDX_W-1:0]  i;
        song_word_t        w;
        s = addr[ADDR_W-1 -: SONG_W];
        i = addr[IDX_W-1:0];
        w = '{note: '0, duration: DUR_END};
        case (s)
            2'd0: begin
                w.note     = NOTE_W'(i) + NOTE_W'(1);
                w.duration = DUR_W'(i % IDX_W'(7)) + DUR_W'(1);
            end
            2'd1: begin
                case (i)
                    5'd0:    w = '{note: 6'd20, duration: 6'd12};
                    5'd1:    w = '{note: 6'd22, duration: 6'd10};
                    5'd2:    w = '{note: 6'd24, duration: 6'd8};
                    5'd3:    w = '{note: 6'd26, duration: 6'd6};
                    5'd4:    w = '{note: 6'd28, duration: 6'd4};
                    5'd5:    w = '{note: 6'd0,  duration: DUR_END};
                    default: w = '{note: 6'd30, duration: 6'd1};
                endcase
            end
            2'd2: begin
                case (i)
                    5'd0:    w = '{note: 6'd40, duration: 6'd3};
                    5'd1:    w = '{note: 6'd41, duration: 6'd5};
                    5'd2:    w = '{note: 6'd42, duration: 6'd7};
                    5'd3:    w = '{note: 6'd0,  duration: DUR_END};
                    default: w = '{note: 6'd50, duration: 6'd2};
                endcase
            end
            default: begin
                w.note     = 6'd63 - NOTE_W'(i);
                w.duration = 6'd48 - DUR_W'(i);
            end
        endcase
        return w;
    endfunction

endpackage

// File: rtl/song_reader_song_rom.sv
// 128 x 12 registered song ROM; data appears one cycle after the address.
module song_rom
    import song_reader_pkg::*;
(
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    output logic [WORD_W-1:0] data
);

    always_ff @(posedge clk) begin
        data <= song_data(addr);
    end

endmodule

// File: rtl/song_reader.sv
// Walks a stored song note by note, handing each word to the note player
// and waiting for its note_done before fetching the next.
module song_reader
    import song_reader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              play,
    input  logic [SONG_W-1:0] song,
    input  logic              note_done,
    output logic [NOTE_W-1:0] note,
    output logic [DUR_W-1:0]  duration,
    output logic              new_note,
    output logic              song_done,
    output logic              playing
);

    state_t            state, state_nx;
    logic [IDX_W-1:0]  index, index_nx;
    logic [SONG_W-1:0] song_q, song_q_nx;
    logic              load_word;
    logic [WORD_W-1:0] rom_data;
    song_word_t        rom_word;

    song_rom u_song_rom (
        .clk  (clk),
        .addr ({song_q, index}),
        .data (rom_data)
    );

    assign rom_word = rom_data;

    // Next-state and index/song bookkeeping.
    always_comb begin
        state_nx  = state;
        index_nx  = index;
        song_q_nx = song_q;
        load_word = 1'b0;
        case (state)
            IDLE: begin
                if (play) begin
                    if (song != song_q) index_nx = '0;
                    song_q_nx = song;
                    state_nx  = FETCH;
                end
            end
            FETCH: state_nx = CHECK;
            CHECK: begin
                if (rom_word.duration == DUR_END) begin
                    state_nx = END;
                end else begin
                    load_word = 1'b1;
                    state_nx  = ISSUE;
                end
            end
            ISSUE: state_nx = WAIT;
            WAIT: begin
                // A pause wins over a coincident note_done so the note is replayed.
                if (!play) begin
                    state_nx = IDLE;
                end else if (note_done) begin
                    if (index == LAST_IDX) begin
                        state_nx = END;
                    end else begin
                        index_nx = index + IDX_W'(1);
                        state_nx = FETCH;
                    end
                end
            end
            END: begin
                index_nx = '0;
                state_nx = HOLD;
            end
            HOLD: begin
                if (!play) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Registered state and outputs; strobes are decoded from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            index     <= '0;
            song_q    <= '0;
            note      <= '0;
            duration  <= '0;
            new_note  <= 1'b0;
            song_done <= 1'b0;
            playing   <= 1'b0;
        end else begin
            state     <= state_nx;
            index     <= index_nx;
            song_q    <= song_q_nx;
            if (load_word) begin
                note     <= rom_word.note;
                duration <= rom_word.duration;
            end
            new_note  <= (state_nx == ISSUE);
            song_done <= (state_nx == END);
            playing   <= (state_nx == FETCH) || (state_nx == CHECK) ||
                         (state_nx == ISSUE) || (state_nx == WAIT);
        end
    end

endmodule

// File: tb/tb_song_reader.sv
// Self-checking bench for song_reader: expected words are queued as songs are
// started and checked by a monitor whenever new_note fires.
module tb_song_reader;
    import song_reader_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              play;
    logic [SONG_W-1:0] song;
    logic              note_done;
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  duration;
    logic              new_note;
    logic              song_done;
    logic              playing;

    int total = 0;
    int bad   = 0;
    int nn_seen = 0;
    int sd_seen = 0;
    logic [11:0] exp_q[$];

    always #5 clk = ~clk;

    song_reader dut (
        .clk       (clk),
        .reset     (reset),
        .play      (play),
        .song      (song),
        .note_done (note_done),
        .note      (note),
        .duration  (duration),
        .new_note  (new_note),
        .song_done (song_done),
        .playing   (playing)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Independent description of the stored songs as {note, duration}.
    function automatic logic [11:0] exp_word(input int s, input int i);
        int n, d;
        case (s)
            0:       begin n = i + 1;      d = (i % 7) + 1; end
            1:       begin n = 20 + 2 * i; d = (i < 5) ? 12 - 2 * i : 0; end
            2:       begin n = 40 + i;     d = (i < 3) ? 3 + 2 * i : 0; end
            default: begin n = 63 - i;     d = 48 - i; end
        endcase
        return {6'(n), 6'(d)};
    endfunction

    // Scoreboard side: every new_note pops one expected word.
    always @(negedge clk) begin
        logic [11:0] w;
        if (new_note === 1'b1) begin
            nn_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_new_note", 1, 0);
            end else begin
                w = exp_q.pop_front();
                check("note", int'(note), int'(w[11:6]));
                check("duration", int'(duration), int'(w[5:0]));
            end
        end
        if (song_done === 1'b1) sd_seen++;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_new_note(input int budget, output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (new_note !== 1'b1 && cycles < budget);
        if (new_note !== 1'b1) check("new_note_timeout", 0, 1);
    endtask

    task automatic pulse_note_done();
        note_done = 1'b1;
        tick();
        note_done = 1'b0;
    endtask

    typedef struct {
        int          song;
        int          n_notes;
        int          gap;
        logic [11:0] first;
    } vec_t;

    task automatic run_song(input vec_t v);
        int c;
        int nn0, sd0;
        logic [11:0] last;
        nn0  = nn_seen;
        sd0  = sd_seen;
        last = exp_word(v.song, v.n_notes - 1);
        song = SONG_W'(v.song);
        for (int i = 0; i < v.n_notes; i++) exp_q.push_back(exp_word(v.song, i));
        play = 1'b1;
        wait_new_note(8, c);
        check("start_latency", c, 3);
        check("first_note", int'(note), int'(v.first[11:6]));
        check("first_duration", int'(duration), int'(v.first[5:0]));
        for (int i = 0; i < v.n_notes; i++) begin
            repeat (v.gap) tick();
            check("playing_in_wait", int'(playing), 1);
            pulse_note_done();
            if (i < v.n_notes - 1) begin
                wait_new_note(8, c);
                check("next_latency", c + 1, 3);
            end
        end
        c = 0;
        while (sd_seen == sd0 && c < 8) begin
            tick();
            c++;
        end
        check("song_done_count", sd_seen - sd0, 1);
        check("new_note_count", nn_seen - nn0, v.n_notes);
        check("note_held", int'(note), int'(last[11:6]));
        check("duration_held", int'(duration), int'(last[5:0]));
        // Held in HOLD while play stays high; stray note_done must do nothing.
        repeat (3) tick();
        pulse_note_done();
        repeat (4) tick();
        check("hold_playing", int'(playing), 0);
        check("hold_no_replay", nn_seen - nn0, v.n_notes);
        check("hold_single_done", sd_seen - sd0, 1);
        play = 1'b0;
        repeat (2) tick();
        pulse_note_done();
        repeat (2) tick();
        check("idle_no_strobe", nn_seen - nn0, v.n_notes);
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        vec_t vecs[4];
        int c, nn0, sd0;

        vecs[0] = '{song: 1, n_notes: 5,  gap: 10, first: {6'd20, 6'd12}};
        vecs[1] = '{song: 2, n_notes: 3,  gap: 2,  first: {6'd40, 6'd3}};
        vecs[2] = '{song: 3, n_notes: 32, gap: 1,  first: {6'd63, 6'd48}};
        vecs[3] = '{song: 0, n_notes: 32, gap: 3,  first: {6'd1,  6'd1}};

        reset     = 1'b1;
        play      = 1'b1;
        song      = '0;
        note_done = 1'b0;

        // Reset held with play high, then released.
        repeat (3) tick();
        check("rst_note", int'(note), 0);
        check("rst_duration", int'(duration), 0);
        check("rst_new_note", int'(new_note), 0);
        check("rst_song_done", int'(song_done), 0);
        check("rst_playing", int'(playing), 0);
        exp_q.push_back(exp_word(0, 0));
        reset = 1'b0;
        wait_new_note(8, c);
        check("rst_release_latency", c, 3);
        tick();
        play = 1'b0;
        repeat (3) tick();

        foreach (vecs[k]) run_song(vecs[k]);

        // Pause on the same cycle as note_done at index 5, then resume.
        song = '0;
        for (int i = 0; i < 6; i++) exp_q.push_back(exp_word(0, i));
        play = 1'b1;
        wait_new_note(8, c);
        for (int i = 0; i < 5; i++) begin
            repeat (3) tick();
            pulse_note_done();
            wait_new_note(8, c);
        end
        repeat (2) tick();
        note_done = 1'b1;
        play      = 1'b0;
        tick();
        note_done = 1'b0;
        repeat (2) tick();
        check("pause_playing", int'(playing), 0);
        check("pause_queue", exp_q.size(), 0);
        nn0 = nn_seen;
        exp_q.push_back(exp_word(0, 5));
        play = 1'b1;
        wait_new_note(8, c);
        check("resume_latency", c, 3);
        check("resume_reissue", nn_seen - nn0, 1);

        // Song change while paused restarts from slot 0 of the new song.
        repeat (2) tick();
        play = 1'b0;
        repeat (3) tick();
        song = 2'd2;
        exp_q.push_back(exp_word(2, 0));
        play = 1'b1;
        wait_new_note(8, c);
        check("switch_latency", c, 3);
        check("switch_note", int'(note), 40);
        repeat (2) tick();
        play = 1'b0;
        repeat (3) tick();

        // Reset while waiting on slot 7.
        song = '0;
        for (int i = 0; i < 8; i++) exp_q.push_back(exp_word(0, i));
        play = 1'b1;
        wait_new_note(8, c);
        for (int i = 0; i < 7; i++) begin
            repeat (2) tick();
            pulse_note_done();
            wait_new_note(8, c);
        end
        check("pre_reset_note", int'(note), 8);
        repeat (2) tick();
        nn0   = nn_seen;
        sd0   = sd_seen;
        reset = 1'b1;
        #1;
        check("midrst_note", int'(note), 0);
        check("midrst_duration", int'(duration), 0);
        check("midrst_playing", int'(playing), 0);
        check("midrst_new_note", int'(new_note), 0);
        repeat (4) tick();
        check("midrst_no_strobe", nn_seen - nn0, 0);
        check("midrst_no_done", sd_seen - sd0, 0);
        exp_q.push_back(exp_word(0, 0));
        reset = 1'b0;
        wait_new_note(8, c);
        check("post_reset_latency", c, 3);
        tick();
        play = 1'b0;
        repeat (3) tick();
        check("final_queue", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
